// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops plus a multi-cycle
// binary-to-BCD conversion (double dabble), one operation in flight at a time.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            operation,
  input  logic [WIDTH-1:0]      X,
  input  logic [WIDTH-1:0]      Y,
  output logic [WIDTH-1:0]      out,
  output logic                  carry_out,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_Y    = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_RSUB = 4'd8;
  localparam logic [3:0] OP_BCD  = 4'd9;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         step_cnt;
  logic [WIDTH-1:0]      shreg;
  logic [4*DIGITS-1:0]   digits, digits_adj, digits_next;
  logic [WIDTH-1:0]      alu_out;
  logic                  alu_carry;
  logic [WIDTH:0]        sum;
  logic                  accept, is_bcd, last_step;

  assign busy      = (state == CONVERT);
  assign accept    = start && !busy;
  assign is_bcd    = (operation == OP_BCD);
  assign last_step = busy && (step_cnt == CW'(WIDTH - 1));
  assign sum       = {1'b0, X} + {1'b0, Y};

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (operation)
      OP_Y:    alu_out = Y;
      OP_OR:   alu_out = X | Y;
      OP_AND:  alu_out = X & Y;
      OP_XOR:  alu_out = X ^ Y;
      OP_ADD:  {alu_carry, alu_out} = sum;
      OP_SUB:  begin alu_out = X - Y; alu_carry = (X >= Y); end
      OP_RSUB: begin alu_out = Y - X; alu_carry = (Y >= X); end
      OP_SHR:  begin alu_out = X >> 1; alu_carry = X[0]; end
      OP_SHL:  begin alu_out = X << 1; alu_carry = X[WIDTH-1]; end
      default: ;
    endcase
  end

  // One double-dabble step: correct digits >= 5, then shift in the operand MSB.
  always_comb begin
    digits_adj = digits;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits[4*i +: 4] >= 4'd5)
        digits_adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
    end
  end

  assign digits_next = {digits_adj[4*DIGITS-2:0], shreg[WIDTH-1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_bcd) state_next = CONVERT;
      CONVERT: if (last_step)        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      carry_out <= 1'b0;
      bcd       <= '0;
      done      <= 1'b0;
      step_cnt  <= '0;
      shreg     <= '0;
      digits    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (is_bcd) begin
          shreg    <= X;
          digits   <= '0;
          step_cnt <= '0;
        end else begin
          out       <= alu_out;
          carry_out <= alu_carry;
          done      <= 1'b1;
        end
      end else if (busy) begin
        shreg    <= shreg << 1;
        digits   <= digits_next;
        step_cnt <= step_cnt + CW'(1);
        if (last_step) begin
          bcd      <= digits_next;
          done     <= 1'b1;
          step_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference
// model; a second 16-bit instance covers the wider shift and BCD cases.
module tb_alu_seq;

  localparam int W   = 8;
  localparam int D   = 3;
  localparam int W16 = 16;
  localparam int D16 = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       operation;
  logic [W-1:0]     X, Y;
  logic [W-1:0]     out;
  logic             carry_out;
  logic [4*D-1:0]   bcd;
  logic             busy, done;

  logic             start16;
  logic [3:0]       op16;
  logic [W16-1:0]   x16, y16, out16;
  logic             carry16, busy16, done16;
  logic [4*D16-1:0] bcd16;

  int tests = 0;
  int fails = 0;

  logic [W-1:0]   exp_out;
  logic           exp_carry;
  logic [4*D-1:0] exp_bcd;

  alu_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .X(X), .Y(Y), .out(out), .carry_out(carry_out), .bcd(bcd),
    .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(W16), .DIGITS(D16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .operation(op16),
    .X(x16), .Y(y16), .out(out16), .carry_out(carry16), .bcd(bcd16),
    .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference model for the single-cycle ops, straight from the op table.
  task automatic model_op(input int op, input int x, input int y);
    int r = 0;
    bit c = 1'b0;
    case (op)
      0: r = y;
      1: r = x | y;
      2: r = x & y;
      3: r = x ^ y;
      4: begin r = x + y; c = (r > 255); end
      5: begin r = x - y; c = (x >= y); end
      6: begin r = x / 2; c = (x % 2 == 1); end
      7: begin r = x * 2; c = (x > 127); end
      8: begin r = y - x; c = (y >= x); end
      default: r = 0;
    endcase
    exp_out   = W'(r);
    exp_carry = c;
  endtask

  // Called at a negedge; returns at the negedge where done is expected.
  task automatic single(input int op, input int x, input int y);
    start = 1'b1; operation = 4'(op); X = W'(x); Y = W'(y);
    model_op(op, x, y);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("op%0d done", op), done, 1);
    check($sformatf("op%0d out x=%0h y=%0h", op, x, y), out, exp_out);
    check($sformatf("op%0d carry x=%0h y=%0h", op, x, y), carry_out, exp_carry);
    check($sformatf("op%0d bcd kept", op), bcd, exp_bcd);
  endtask

  task automatic convert(input int x, input bit inject);
    int n = 1;
    int busy_cnt = 0;
    int extra = 0;
    start = 1'b1; operation = 4'd9; X = W'(x); Y = W'($urandom);
    exp_bcd = to_bcd(x);
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      if (inject && n == 3) begin
        start = 1'b1; operation = 4'd4; X = 8'hFF; Y = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check($sformatf("bcd done x=%0d", x), done, 1);
    check($sformatf("bcd latency x=%0d", x), n, W + 1);
    check($sformatf("bcd busy cycles x=%0d", x), busy_cnt, W);
    check($sformatf("bcd value x=%0d", x), bcd, exp_bcd);
    check("bcd out kept", out, exp_out);
    check("bcd carry kept", carry_out, exp_carry);
    @(negedge clk);
    check("bcd done one cycle", done, 0);
    if (inject) begin
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("ignored start gave no done", extra, 0);
      check("ignored start out kept", out, exp_out);
    end
  endtask

  initial begin
    int n;
    int extra;
    reset = 1'b1; start = 1'b0; operation = '0; X = '0; Y = '0;
    start16 = 1'b0; op16 = '0; x16 = '0; y16 = '0;
    exp_out = '0; exp_carry = 1'b0; exp_bcd = '0;
    repeat (2) @(negedge clk);
    check("reset out", out, 0);
    check("reset carry", carry_out, 0);
    check("reset bcd", bcd, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);

    reset = 1'b0;
    single(4, 8'hFF, 8'h01);
    @(negedge clk);
    check("done single pulse", done, 0);
    single(5, 8'h05, 8'h05);
    single(5, 8'h03, 8'h05);
    single(8, 8'h03, 8'h05);
    single(12, 8'h5A, 8'hA5);
    convert(8'hFF, 1'b0);
    convert(8'h00, 1'b0);
    single(7, 8'h81, 8'h00);
    convert(123, 1'b1);

    for (int i = 0; i < 60; i++) begin
      int op = $urandom_range(0, 15);
      int x  = $urandom_range(0, 255);
      int y  = $urandom_range(0, 255);
      if (op == 9) convert(x, 1'b0);
      else         single(op, x, y);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check("idle done low", done, 0);
      end
    end

    // Reset in the middle of a conversion.
    single(4, 8'h12, 8'h34);
    convert(8'hFF, 1'b0);
    start = 1'b1; operation = 4'd9; X = 8'h80;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset out", out, 0);
    check("mid reset carry", carry_out, 0);
    check("mid reset bcd", bcd, 0);
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("no done after reset", extra, 0);
    exp_out = '0; exp_carry = 1'b0; exp_bcd = '0;
    single(3, 8'hF0, 8'h3C);

    // 16-bit instance.
    @(negedge clk);
    start16 = 1'b1; op16 = 4'd7; x16 = 16'h8001;
    @(negedge clk);
    start16 = 1'b0;
    check("w16 shl done", done16, 1);
    check("w16 shl out", out16, 16'h0002);
    check("w16 shl carry", carry16, 1);
    start16 = 1'b1; op16 = 4'd6; x16 = 16'h8001;
    @(negedge clk);
    start16 = 1'b0;
    check("w16 shr out", out16, 16'h4000);
    check("w16 shr carry", carry16, 1);
    start16 = 1'b1; op16 = 4'd9; x16 = 16'hFFFF;
    @(negedge clk);
    start16 = 1'b0;
    n = 1;
    while (!done16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("w16 bcd latency", n, W16 + 1);
    check("w16 bcd value", bcd16, 20'h65535);
    check("w16 bcd out kept", out16, 16'h4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
